// File: rtl/traffic_light_monitor.sv
// Passive protocol checker for a RED -> GREEN -> YELLOW traffic light controller.
// Flags one-hot, ordering, phase-duration and countdown violations as pulses and sticky bits.
module traffic_light_monitor #(
  parameter int CL_PERIOD_TIME    = 100,
  parameter int YELLOW_LIGHT_TIME = 3,
  parameter int RED_LIGHT_TIME    = 18,
  parameter int GREEN_LIGHT_TIME  = 15,
  parameter int pCount_Width      = $clog2(RED_LIGHT_TIME)
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    en,
  input  logic                    clr_err,
  input  logic                    red_light,
  input  logic                    green_light,
  input  logic                    yellow_light,
  input  logic [pCount_Width-1:0] cnt_in_num,
  output logic [1:0]              phase,
  output logic [3:0]              err_pulse,
  output logic [3:0]              err_sticky,
  output logic [7:0]              cycle_cnt
);

  localparam int DUR_W = $clog2(RED_LIGHT_TIME * CL_PERIOD_TIME + 2);
  localparam logic [DUR_W-1:0] DUR_RED    = DUR_W'(RED_LIGHT_TIME * CL_PERIOD_TIME);
  localparam logic [DUR_W-1:0] DUR_GREEN  = DUR_W'(GREEN_LIGHT_TIME * CL_PERIOD_TIME);
  localparam logic [DUR_W-1:0] DUR_YELLOW = DUR_W'(YELLOW_LIGHT_TIME * CL_PERIOD_TIME);

  typedef enum logic [1:0] {ST_SYNC, ST_FIRST, ST_TRACK} mon_state_t;
  typedef enum logic [1:0] {PH_NONE = 2'd0, PH_RED = 2'd1, PH_GREEN = 2'd2, PH_YELLOW = 2'd3} phase_t;

  mon_state_t              r_state;
  phase_t                  r_phase;
  logic [DUR_W-1:0]        r_dur_cnt;
  logic [pCount_Width-1:0] r_prev_cnt;
  logic [3:0]              r_err_pulse;
  logic [3:0]              r_err_sticky;
  logic [7:0]              r_cycle_cnt;

  logic [2:0]       w_lights;
  logic             w_valid;
  phase_t           w_dec;
  logic             w_legal;
  logic [DUR_W-1:0] w_exp_dur;
  logic [3:0]       w_pulse;

  assign w_lights = {yellow_light, green_light, red_light};
  assign w_valid  = $onehot(w_lights);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_dec     = PH_NONE;
    w_legal   = 1'b0;
    w_exp_dur = '0;
    w_pulse   = '0;

    unique case (w_lights)
      3'b001:  w_dec = PH_RED;
      3'b010:  w_dec = PH_GREEN;
      3'b100:  w_dec = PH_YELLOW;
      default: w_dec = PH_NONE;
    endcase

    // Expected length and legal successor of the phase currently being tracked.
    case (r_phase)
      PH_RED:    begin w_exp_dur = DUR_RED;    w_legal = (w_dec == PH_GREEN);  end
      PH_GREEN:  begin w_exp_dur = DUR_GREEN;  w_legal = (w_dec == PH_YELLOW); end
      PH_YELLOW: begin w_exp_dur = DUR_YELLOW; w_legal = (w_dec == PH_RED);    end
      default:   begin w_exp_dur = '0;         w_legal = 1'b0;                 end
    endcase

    if (en) begin
      if (!w_valid) begin
        w_pulse[0] = 1'b1;
      end else if (r_state != ST_SYNC) begin
        if (w_dec != r_phase) begin
          w_pulse[1] = !w_legal;
          w_pulse[2] = (r_state == ST_TRACK) && (r_dur_cnt != w_exp_dur);
        end else if (cnt_in_num != r_prev_cnt) begin
          // A step from zero would alias to all-ones, so it is rejected explicitly.
          w_pulse[3] = (r_prev_cnt == '0) ||
                       (cnt_in_num != r_prev_cnt - pCount_Width'(1));
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_state      <= ST_SYNC;
      r_phase      <= PH_NONE;
      r_dur_cnt    <= '0;
      r_prev_cnt   <= '0;
      r_err_pulse  <= '0;
      r_err_sticky <= '0;
      r_cycle_cnt  <= '0;
    end else begin
      r_err_pulse  <= w_pulse;
      // The visible pulse is folded in too, so a clear coincident with it cannot drop it.
      r_err_sticky <= (clr_err ? 4'b0000 : r_err_sticky) | r_err_pulse | w_pulse;

      if (en) begin
        r_prev_cnt <= cnt_in_num;
        if (!w_valid) begin
          r_state   <= ST_SYNC;
          r_phase   <= PH_NONE;
          r_dur_cnt <= '0;
        end else if (r_state == ST_SYNC) begin
          r_state   <= ST_FIRST;
          r_phase   <= w_dec;
          r_dur_cnt <= DUR_W'(1);
        end else if (w_dec != r_phase) begin
          r_phase   <= w_dec;
          r_dur_cnt <= DUR_W'(1);
          if (w_legal) begin
            r_state <= ST_TRACK;
            if (r_state == ST_TRACK && r_phase == PH_YELLOW)
              r_cycle_cnt <= r_cycle_cnt + 8'd1;
          end
        end else if (r_dur_cnt != '1) begin
          r_dur_cnt <= r_dur_cnt + DUR_W'(1);
        end
      end
    end
  end

  assign phase      = r_phase;
  assign err_pulse  = r_err_pulse;
  assign err_sticky = r_err_sticky;
  assign cycle_cnt  = r_cycle_cnt;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with CL=4, RED=3, GREEN=2, YELLOW=1
// (phase lengths 12/8/4 clocks); expectations are hand-derived per scenario.
module tb_traffic_light_monitor;

  localparam int CL = 4;
  localparam int RL = 12;
  localparam int GL = 8;
  localparam int YL = 4;

  logic       clk = 1'b0;
  logic       rstb;
  logic       en;
  logic       clr_err;
  logic       red_light, green_light, yellow_light;
  logic [3:0] cnt_in_num;
  logic [1:0] phase;
  logic [3:0] err_pulse;
  logic [3:0] err_sticky;
  logic [7:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  traffic_light_monitor #(
    .CL_PERIOD_TIME   (CL),
    .YELLOW_LIGHT_TIME(1),
    .RED_LIGHT_TIME   (3),
    .GREEN_LIGHT_TIME (2),
    .pCount_Width     (4)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .en          (en),
    .clr_err     (clr_err),
    .red_light   (red_light),
    .green_light (green_light),
    .yellow_light(yellow_light),
    .cnt_in_num  (cnt_in_num),
    .phase       (phase),
    .err_pulse   (err_pulse),
    .err_sticky  (err_sticky),
    .cycle_cnt   (cycle_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lights(input logic [1:0] ph);
    red_light    = (ph == 2'd1);
    green_light  = (ph == 2'd2);
    yellow_light = (ph == 2'd3);
  endtask

  // Drives one phase with a correct countdown; returns OR of pulses and phase after the first cycle.
  task automatic run_phase(input logic [1:0] ph, input int len,
                           output logic [3:0] seen, output logic [1:0] ph_first);
    seen     = '0;
    ph_first = '0;
    for (int i = 0; i < len; i++) begin
      set_lights(ph);
      en         = 1'b1;
      cnt_in_num = 4'((len - 1 - i) / CL);
      tick();
      seen |= err_pulse;
      if (i == 0) ph_first = phase;
    end
  endtask

  task automatic do_reset();
    en = 1'b0; clr_err = 1'b0; cnt_in_num = '0;
    set_lights(2'd0);
    rstb = 1'b1;
    tick();
    rstb = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    checks++; if (err_pulse !== 4'h0) begin errors++; $display("FAIL reset_pulse: got %h expected 0", err_pulse); end
    checks++; if (err_sticky !== 4'h0) begin errors++; $display("FAIL reset_sticky: got %h expected 0", err_sticky); end
    checks++; if (cycle_cnt !== 8'd0) begin errors++; $display("FAIL reset_cycle_cnt: got %0d expected 0", cycle_cnt); end
  endtask

  task automatic test_nominal();
    logic [3:0] seen, all_seen;
    logic [1:0] pf;
    do_reset();
    all_seen = '0;
    for (int k = 0; k < 3; k++) begin
      run_phase(2'd1, RL, seen, pf); all_seen |= seen;
      checks++; if (pf !== 2'd1) begin errors++; $display("FAIL nominal_phase_red: got %0d expected 1", pf); end
      run_phase(2'd2, GL, seen, pf); all_seen |= seen;
      checks++; if (pf !== 2'd2) begin errors++; $display("FAIL nominal_phase_green: got %0d expected 2", pf); end
      run_phase(2'd3, YL, seen, pf); all_seen |= seen;
      checks++; if (pf !== 2'd3) begin errors++; $display("FAIL nominal_phase_yellow: got %0d expected 3", pf); end
    end
    run_phase(2'd1, 1, seen, pf); all_seen |= seen;
    checks++; if (all_seen !== 4'h0) begin errors++; $display("FAIL nominal_pulses: got %h expected 0", all_seen); end
    checks++; if (cycle_cnt !== 8'd3) begin errors++; $display("FAIL nominal_cycle_cnt: got %0d expected 3", cycle_cnt); end
    checks++; if (err_sticky !== 4'h0) begin errors++; $display("FAIL nominal_sticky: got %h expected 0", err_sticky); end
  endtask

  task automatic test_short_green();
    logic [3:0] seen, all_seen;
    logic [1:0] pf;
    do_reset();
    run_phase(2'd1, 5, seen, pf); all_seen = seen;
    run_phase(2'd2, GL, seen, pf); all_seen |= seen;
    run_phase(2'd3, YL, seen, pf); all_seen |= seen;
    run_phase(2'd1, RL, seen, pf); all_seen |= seen;
    run_phase(2'd2, GL - 1, seen, pf); all_seen |= seen;
    checks++; if (all_seen !== 4'h0) begin errors++; $display("FAIL short_green_lead_in: got %h expected 0", all_seen); end
    set_lights(2'd3); cnt_in_num = 4'd0;
    tick();
    checks++; if (err_pulse !== 4'b0100) begin errors++; $display("FAIL short_green_pulse: got %b expected 0100", err_pulse); end
    tick();
    checks++; if (err_pulse !== 4'b0000) begin errors++; $display("FAIL short_green_one_cycle: got %b expected 0000", err_pulse); end
    checks++; if (err_sticky !== 4'b0100) begin errors++; $display("FAIL short_green_sticky: got %b expected 0100", err_sticky); end
  endtask

  task automatic test_illegal_order();
    logic [3:0] seen;
    logic [1:0] pf;
    do_reset();
    run_phase(2'd1, 5, seen, pf);
    run_phase(2'd2, GL, seen, pf);
    run_phase(2'd3, YL, seen, pf);
    run_phase(2'd1, RL, seen, pf);
    checks++; if (cycle_cnt !== 8'd1) begin errors++; $display("FAIL illegal_pre_cycle_cnt: got %0d expected 1", cycle_cnt); end
    set_lights(2'd3); cnt_in_num = 4'd0;
    tick();
    checks++; if (err_pulse !== 4'b0010) begin errors++; $display("FAIL illegal_seq_pulse: got %b expected 0010", err_pulse); end
    checks++; if (phase !== 2'd3) begin errors++; $display("FAIL illegal_phase: got %0d expected 3", phase); end
    for (int i = 1; i < YL; i++) tick();
    set_lights(2'd1); cnt_in_num = 4'd2;
    tick();
    checks++; if (err_pulse !== 4'b0000) begin errors++; $display("FAIL illegal_recover_pulse: got %b expected 0000", err_pulse); end
    checks++; if (cycle_cnt !== 8'd2) begin errors++; $display("FAIL illegal_cycle_cnt: got %0d expected 2", cycle_cnt); end
  endtask

  task automatic test_invalid_lights();
    logic [3:0] seen;
    logic [1:0] pf;
    do_reset();
    run_phase(2'd1, 5, seen, pf);
    run_phase(2'd2, GL, seen, pf);
    red_light = 1'b1; green_light = 1'b1; yellow_light = 1'b0;
    tick();
    checks++; if (err_pulse !== 4'b0001) begin errors++; $display("FAIL invalid_pulse_1: got %b expected 0001", err_pulse); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL invalid_phase: got %0d expected 0", phase); end
    tick();
    checks++; if (err_pulse !== 4'b0001) begin errors++; $display("FAIL invalid_pulse_2: got %b expected 0001", err_pulse); end
    run_phase(2'd1, 5, seen, pf);
    checks++; if (pf !== 2'd1) begin errors++; $display("FAIL invalid_first_phase: got %0d expected 1", pf); end
    set_lights(2'd2); cnt_in_num = 4'd1;
    tick();
    checks++; if (err_pulse !== 4'b0000) begin errors++; $display("FAIL invalid_first_no_dur: got %b expected 0000", err_pulse); end
    checks++; if (err_sticky !== 4'b0001) begin errors++; $display("FAIL invalid_sticky: got %b expected 0001", err_sticky); end
  endtask

  task automatic test_countdown();
    do_reset();
    en = 1'b1; set_lights(2'd1);
    cnt_in_num = 4'd5; tick();
    tick();
    cnt_in_num = 4'd4; tick();
    checks++; if (err_pulse !== 4'b0000) begin errors++; $display("FAIL cd_good_step: got %b expected 0000", err_pulse); end
    cnt_in_num = 4'd2; tick();
    checks++; if (err_pulse !== 4'b1000) begin errors++; $display("FAIL cd_skip_pulse: got %b expected 1000", err_pulse); end
    clr_err = 1'b1; tick();
    checks++; if (err_pulse !== 4'b0000) begin errors++; $display("FAIL cd_single_pulse: got %b expected 0000", err_pulse); end
    checks++; if (err_sticky !== 4'b1000) begin errors++; $display("FAIL cd_set_wins: got %b expected 1000", err_sticky); end
    tick();
    checks++; if (err_sticky !== 4'b0000) begin errors++; $display("FAIL cd_clear: got %b expected 0000", err_sticky); end
    clr_err = 1'b0;
    cnt_in_num = 4'd1; tick();
    cnt_in_num = 4'd0; tick();
    checks++; if (err_pulse !== 4'b0000) begin errors++; $display("FAIL cd_to_zero: got %b expected 0000", err_pulse); end
    cnt_in_num = 4'd15; tick();
    checks++; if (err_pulse !== 4'b1000) begin errors++; $display("FAIL cd_wrap: got %b expected 1000", err_pulse); end
  endtask

  task automatic test_freeze_reset();
    logic [3:0] seen, all_seen;
    logic [1:0] pf;
    do_reset();
    run_phase(2'd1, 5, seen, pf); all_seen = seen;
    run_phase(2'd2, GL, seen, pf); all_seen |= seen;
    run_phase(2'd3, YL, seen, pf); all_seen |= seen;
    for (int i = 0; i < RL; i++) begin
      if (i == 6) begin
        en = 1'b0; red_light = 1'b1; green_light = 1'b1; cnt_in_num = 4'd9;
        for (int j = 0; j < 10; j++) begin tick(); all_seen |= err_pulse; end
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL freeze_phase_hold: got %0d expected 1", phase); end
      end
      en = 1'b1; set_lights(2'd1); cnt_in_num = 4'((RL - 1 - i) / CL);
      tick(); all_seen |= err_pulse;
    end
    set_lights(2'd2); cnt_in_num = 4'd1;
    tick(); all_seen |= err_pulse;
    checks++; if (all_seen !== 4'h0) begin errors++; $display("FAIL freeze_no_errors: got %h expected 0", all_seen); end
    checks++; if (cycle_cnt !== 8'd1) begin errors++; $display("FAIL freeze_cycle_cnt: got %0d expected 1", cycle_cnt); end
    cnt_in_num = 4'd3; tick();
    checks++; if (err_sticky !== 4'b1000) begin errors++; $display("FAIL pre_reset_sticky: got %b expected 1000", err_sticky); end
    #2 rstb = 1'b1;
    #1;
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL async_reset_phase: got %0d expected 0", phase); end
    checks++; if (err_pulse !== 4'h0) begin errors++; $display("FAIL async_reset_pulse: got %h expected 0", err_pulse); end
    checks++; if (err_sticky !== 4'h0) begin errors++; $display("FAIL async_reset_sticky: got %h expected 0", err_sticky); end
    checks++; if (cycle_cnt !== 8'd0) begin errors++; $display("FAIL async_reset_cycle_cnt: got %0d expected 0", cycle_cnt); end
    tick();
    rstb = 1'b0;
  endtask

  initial begin
    rstb = 1'b0; en = 1'b0; clr_err = 1'b0; cnt_in_num = '0;
    red_light = 1'b0; green_light = 1'b0; yellow_light = 1'b0;
    test_reset();
    test_nominal();
    test_short_green();
    test_illegal_order();
    test_invalid_lights();
    test_countdown();
    test_freeze_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
